// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the shared
// instruction/data memory arbiter. slave = arbiter view, master = environment.
interface imem_arbiter_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_flush;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  logic        o_err;
  logic        o_err_src;

  modport slave (
    input  f_req, f_addr, f_flush,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  m_gnt, m_rvalid, m_rdata,
    output f_gnt, f_rvalid, f_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_be, m_addr, m_wdata,
    output o_err, o_err_src
  );

  modport master (
    output f_req, f_addr, f_flush,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output m_gnt, m_rvalid, m_rdata,
    input  f_gnt, f_rvalid, f_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_be, m_addr, m_wdata,
    input  o_err, o_err_src
  );
endinterface

// File: rtl/imem_arbiter.sv
// One-outstanding-transaction arbiter sharing a single-ported memory between
// fetch and load/store, with starvation guard, fetch flush and response timeout.
//
// Handshakes: a requester holds *_req (and its fields) until it sees *_gnt in
// the same cycle; the arbiter holds m_req and its fields stable until m_gnt;
// f_rvalid/d_rvalid and o_err are single-cycle pulses with no back-pressure.
module imem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 8
) (
  input  logic           clk,
  input  logic           rst,
  imem_arbiter_if.slave  bus,
  output logic [1:0]     state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  state_e            state_q;
  logic              owner_q;   // 0 = fetch, 1 = data
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              kill_q;
  logic [SC_W-1:0]   starve_q;
  logic [SC_W-1:0]   starve_d;
  logic [CNT_W-1:0]  tmo_q;

  logic f_elig, fetch_wins, in_idle, in_wait, rsp, tmo_hit;
  logic f_gnt_w, d_gnt_w;

  always_comb begin
    f_elig     = bus.f_req && !bus.f_flush;
    fetch_wins = f_elig && (!bus.d_req || (starve_q == SC_W'(STARVE_LIMIT)));
    in_idle    = (state_q == IDLE) && !rst;
    in_wait    = (state_q == WAIT) && !rst;
    f_gnt_w    = in_idle && fetch_wins;
    d_gnt_w    = in_idle && bus.d_req && !fetch_wins;
    rsp        = in_wait && bus.m_rvalid;
    tmo_hit    = in_wait && !bus.m_rvalid && (tmo_q == CNT_W'(TIMEOUT - 1));
    // Data grant while fetch waits extends the streak; otherwise the streak ends.
    starve_d   = '0;
    if (bus.f_req) begin
      starve_d = (starve_q == SC_W'(STARVE_LIMIT)) ? starve_q : starve_q + SC_W'(1);
    end
  end

  assign bus.f_gnt     = f_gnt_w;
  assign bus.d_gnt     = d_gnt_w;
  // A flush arriving together with the response still suppresses it.
  assign bus.f_rvalid  = rsp && !owner_q && !kill_q && !bus.f_flush;
  assign bus.f_rdata   = bus.f_rvalid ? bus.m_rdata : 32'h0;
  assign bus.d_rvalid  = rsp && owner_q;
  assign bus.d_rdata   = bus.d_rvalid ? bus.m_rdata : 32'h0;
  assign bus.m_req     = (state_q == REQ) && !rst;
  assign bus.m_we      = we_q;
  assign bus.m_be      = be_q;
  assign bus.m_addr    = addr_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.o_err     = tmo_hit;
  assign bus.o_err_src = tmo_hit && owner_q;
  assign state_o       = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 4'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      kill_q   <= 1'b0;
      starve_q <= '0;
      tmo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          kill_q <= 1'b0;
          if (f_gnt_w) begin
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'hF;
            addr_q   <= bus.f_addr;
            wdata_q  <= 32'h0;
            starve_q <= '0;
            state_q  <= REQ;
          end else if (d_gnt_w) begin
            owner_q  <= 1'b1;
            we_q     <= bus.d_we;
            be_q     <= bus.d_be;
            addr_q   <= bus.d_addr;
            wdata_q  <= bus.d_wdata;
            starve_q <= starve_d;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (bus.f_flush && !owner_q) kill_q <= 1'b1;
          if (bus.m_gnt) begin
            tmo_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.f_flush && !owner_q) kill_q <= 1'b1;
          tmo_q <= tmo_q + CNT_W'(1);
          if (bus.m_rvalid || tmo_hit) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed and randomized checks of imem_arbiter against a small reference
// model of grant order, memory contents and response routing.
module tb_imem_arbiter;
  localparam int SL  = 4;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;

  imem_arbiter_if bus ();

  imem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem[int];

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.f_req = 0; bus.f_addr = 0; bus.f_flush = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_be = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.m_gnt = 0; bus.m_rvalid = 0; bus.m_rdata = 0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".state"}, 32'(state), 0);
    chk({tag, ".f_gnt"}, 32'(bus.f_gnt), 0);
    chk({tag, ".d_gnt"}, 32'(bus.d_gnt), 0);
    chk({tag, ".f_rvalid"}, 32'(bus.f_rvalid), 0);
    chk({tag, ".d_rvalid"}, 32'(bus.d_rvalid), 0);
    chk({tag, ".f_rdata"}, bus.f_rdata, 0);
    chk({tag, ".d_rdata"}, bus.d_rdata, 0);
    chk({tag, ".m_req"}, 32'(bus.m_req), 0);
    chk({tag, ".m_we"}, 32'(bus.m_we), 0);
    chk({tag, ".m_be"}, 32'(bus.m_be), 0);
    chk({tag, ".m_addr"}, bus.m_addr, 0);
    chk({tag, ".m_wdata"}, bus.m_wdata, 0);
    chk({tag, ".o_err"}, 32'(bus.o_err), 0);
    chk({tag, ".o_err_src"}, 32'(bus.o_err_src), 0);
  endtask

  // Called at the start of the REQ cycle; returns at the next IDLE cycle.
  task automatic mem_phase(input logic owner_d, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int gnt_wait, input int rv_wait, input int flush_at,
                           input logic [31:0] rdata, input logic exp_valid);
    logic v;
    for (int i = 0; i <= gnt_wait; i++) begin
      bus.m_gnt    = (i == gnt_wait);
      bus.m_rvalid = 1'($urandom_range(0, 1));
      bus.m_rdata  = $urandom;
      #1;
      chk("req.state", 32'(state), 1);
      chk("req.m_req", 32'(bus.m_req), 1);
      chk("req.m_we", 32'(bus.m_we), 32'(we));
      chk("req.m_be", 32'(bus.m_be), 32'(be));
      chk("req.m_addr", bus.m_addr, addr);
      chk("req.m_wdata", bus.m_wdata, wdata);
      chk("req.f_rvalid", 32'(bus.f_rvalid), 0);
      chk("req.d_rvalid", 32'(bus.d_rvalid), 0);
      step();
    end
    for (int i = 0; i <= rv_wait; i++) begin
      bus.m_gnt    = 1'($urandom_range(0, 1));
      bus.m_rvalid = (i == rv_wait);
      bus.m_rdata  = (i == rv_wait) ? rdata : $urandom;
      bus.f_flush  = (i == flush_at);
      #1;
      v = (i == rv_wait) && exp_valid;
      chk("wait.state", 32'(state), 2);
      chk("wait.m_req", 32'(bus.m_req), 0);
      chk("wait.f_rvalid", 32'(bus.f_rvalid), 32'(v && !owner_d));
      chk("wait.d_rvalid", 32'(bus.d_rvalid), 32'(v && owner_d));
      chk("wait.f_rdata", bus.f_rdata, (v && !owner_d) ? rdata : 32'h0);
      chk("wait.d_rdata", bus.d_rdata, (v && owner_d) ? rdata : 32'h0);
      chk("wait.o_err", 32'(bus.o_err), 0);
      step();
    end
    bus.m_gnt = 0; bus.m_rvalid = 0; bus.m_rdata = 0; bus.f_flush = 0;
  endtask

  // Called at the start of the REQ cycle; memory never answers.
  task automatic timeout_phase(input logic owner_d, input logic flush);
    bus.m_gnt = 1;
    #1;
    chk("tmo.m_req", 32'(bus.m_req), 1);
    step();
    bus.m_gnt = 0;
    for (int i = 1; i <= TMO; i++) begin
      bus.f_flush = flush && (i == 2);
      #1;
      chk("tmo.state", 32'(state), 2);
      chk("tmo.o_err", 32'(bus.o_err), 32'(i == TMO));
      chk("tmo.o_err_src", 32'(bus.o_err_src), (i == TMO) ? 32'(owner_d) : 0);
      chk("tmo.f_rvalid", 32'(bus.f_rvalid), 0);
      chk("tmo.d_rvalid", 32'(bus.d_rvalid), 0);
      step();
    end
    bus.f_flush = 0;
    bus.m_rvalid = 1; bus.m_rdata = 32'hCAFE_F00D;
    #1;
    chk("tmo.idle", 32'(state), 0);
    chk("tmo.o_err_after", 32'(bus.o_err), 0);
    chk("tmo.stray_f", 32'(bus.f_rvalid), 0);
    chk("tmo.stray_d", 32'(bus.d_rvalid), 0);
    chk("tmo.stray_rd", bus.f_rdata | bus.d_rdata, 0);
    step();
    bus.m_rvalid = 0; bus.m_rdata = 0;
  endtask

  // ---------------- reference memory ----------------
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] w);
    logic [31:0] cur;
    cur = mem_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = w[8*b +: 8];
    mem[int'(a)] = cur;
  endtask

  // ---------------- stimulus ----------------
  logic exp_is_f [6];
  int   streak;
  bit   pf, pd, win_f;
  logic [31:0] fa, da, dw, rsp_v;
  logic        dwe;
  logic [3:0]  dbe;

  task automatic new_data();
    pd = 1; dwe = 1'($urandom_range(0, 1)); dbe = 4'($urandom_range(1, 15));
    da = 32'($urandom_range(0, 7)) << 2; dw = $urandom;
  endtask

  initial begin
    exp_is_f = '{0, 0, 0, 0, 1, 0};
    clear_inputs();
    rst = 1;
    bus.d_req = 1;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    bus.d_req = 0;
    rst = 0;
    step();
    check_quiet("post_reset");

    // Single fetch at minimum latency
    bus.f_req = 1; bus.f_addr = 32'h100;
    #1;
    chk("t1.f_gnt", 32'(bus.f_gnt), 1);
    chk("t1.d_gnt", 32'(bus.d_gnt), 0);
    step();
    bus.f_req = 0; bus.f_addr = 32'hFFFF_FFFF;
    mem_phase(0, 0, 4'hF, 32'h100, 32'h0, 0, 0, -1, 32'h0000_0013, 1);
    chk("t1.idle", 32'(state), 0);

    // Both requesters held: starvation guard lets fetch win the fifth grant
    bus.f_req = 1; bus.f_addr = 32'h300;
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h400;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t2.f_gnt", 32'(bus.f_gnt), 32'(exp_is_f[k]));
      chk("t2.d_gnt", 32'(bus.d_gnt), 32'(!exp_is_f[k]));
      step();
      if (exp_is_f[k]) mem_phase(0, 0, 4'hF, 32'h300, 32'h0, 0, 0, -1, 32'h1000 + k, 1);
      else             mem_phase(1, 0, 4'hF, 32'h400, 32'h0, 0, 0, -1, 32'h2000 + k, 1);
    end
    clear_inputs();

    // Data write held through three cycles without m_gnt
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t3.d_gnt", 32'(bus.d_gnt), 1);
    step();
    clear_inputs();
    mem_phase(1, 1, 4'b0011, 32'h2000, 32'hDEAD_BEEF, 3, 1, -1, 32'h0, 1);

    // Flush during WAIT drops the fetch response; next fetch granted at once
    bus.f_req = 1; bus.f_addr = 32'h200;
    #1;
    chk("t4.f_gnt", 32'(bus.f_gnt), 1);
    step();
    bus.f_req = 0;
    mem_phase(0, 0, 4'hF, 32'h200, 32'h0, 0, 2, 1, 32'hAAAA_5555, 0);
    bus.f_req = 1; bus.f_addr = 32'h204;
    #1;
    chk("t4.next_gnt", 32'(bus.f_gnt), 1);
    step();
    bus.f_req = 0;
    // Flush coinciding with the response also suppresses it
    mem_phase(0, 0, 4'hF, 32'h204, 32'h0, 1, 1, 1, 32'h1234_5678, 0);
    // Flush while data owns the bus has no effect
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h40;
    #1;
    chk("t4.d_gnt", 32'(bus.d_gnt), 1);
    step();
    bus.d_req = 0;
    mem_phase(1, 0, 4'hF, 32'h40, 32'h0, 0, 2, 1, 32'h0BAD_CAFE, 1);
    // Flush in IDLE makes the fetch request ineligible
    bus.f_req = 1; bus.f_flush = 1;
    #1;
    chk("t4.flush_nogrant", 32'(bus.f_gnt), 0);
    bus.f_flush = 0;
    #1;
    chk("t4.flush_release", 32'(bus.f_gnt), 1);
    step();
    bus.f_req = 0;
    mem_phase(0, 0, 4'hF, 32'h204, 32'h0, 0, 0, -1, 32'h7777_0001, 1);

    // Timeouts: data owner, then killed fetch
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
    #1;
    chk("t5.d_gnt", 32'(bus.d_gnt), 1);
    step();
    bus.d_req = 0;
    timeout_phase(1, 0);
    bus.f_req = 1; bus.f_addr = 32'h88;
    #1;
    chk("t5.f_gnt", 32'(bus.f_gnt), 1);
    step();
    bus.f_req = 0;
    timeout_phase(0, 1);

    // Reset in WAIT abandons the transaction
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'hF; bus.d_addr = 32'hC0; bus.d_wdata = 32'h55;
    #1;
    chk("t6.d_gnt", 32'(bus.d_gnt), 1);
    step();
    clear_inputs();
    bus.m_gnt = 1;
    step();
    bus.m_gnt = 0; rst = 1;
    step();
    rst = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h9999_9999;
    #1;
    check_quiet("t6.after_rst");
    step();
    bus.m_rvalid = 0; bus.m_rdata = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'hC4;
    #1;
    chk("t6.regrant", 32'(bus.d_gnt), 1);
    step();
    bus.d_req = 0;
    mem_phase(1, 0, 4'hF, 32'hC4, 32'h0, 0, 0, -1, 32'h4242_4242, 1);

    // Randomized traffic against the reference model (streak restarts at 0:
    // the previous grant was data with no fetch pending)
    streak = 0; pf = 0; pd = 0;
    for (int t = 0; t < 40; t++) begin
      if (!pf && $urandom_range(0, 1) == 1) begin pf = 1; fa = 32'($urandom_range(0, 7)) << 2; end
      if (!pd && $urandom_range(0, 1) == 1) new_data();
      if (!pf && !pd) new_data();
      bus.f_req = pf; bus.f_addr = fa;
      bus.d_req = pd; bus.d_we = dwe; bus.d_be = dbe; bus.d_addr = da; bus.d_wdata = dw;
      win_f = pf && (!pd || streak == SL);
      #1;
      chk("rnd.f_gnt", 32'(bus.f_gnt), 32'(win_f));
      chk("rnd.d_gnt", 32'(bus.d_gnt), 32'(!win_f));
      if (win_f) begin
        streak = 0;
        exp_q.push_back(mem_rd(fa));
      end else begin
        streak = pf ? ((streak < SL) ? streak + 1 : SL) : 0;
        if (dwe) begin exp_q.push_back($urandom); mem_wr(da, dbe, dw); end
        else exp_q.push_back(mem_rd(da));
      end
      step();
      rsp_v = exp_q.pop_front();
      if (win_f) begin
        pf = 0; bus.f_req = 0;
        mem_phase(0, 0, 4'hF, fa, 32'h0, $urandom_range(0, 2), $urandom_range(0, 2), -1, rsp_v, 1);
      end else begin
        pd = 0; bus.d_req = 0;
        mem_phase(1, dwe, dbe, da, dw, $urandom_range(0, 2), $urandom_range(0, 2), -1, rsp_v, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
